// File: rtl/i2c_uart_pkg.sv
// Shared types and helpers for the I2C-result-to-UART frame scheduler.
//   tx_frame_t     : {addr, mode, data} frame at the default widths (AW=8, DW=16)
//   VALID_PC/DEF   : i2c_valid_instr codes for PC-instruction results / default samples
//   OP_* / ENC_*   : one-hot op inputs and their 2-bit encodings in toPC_mode[1:0]
//   fail_compress  : folds the 7 controller failure flags into the 6 mode bits
//   op_encode      : one-hot op -> 2-bit code, anything not one-hot -> rd1 code
package i2c_uart_pkg;

    localparam int PKG_AW = 8;
    localparam int PKG_DW = 16;

    localparam logic [1:0] VALID_PC  = 2'b11;
    localparam logic [1:0] VALID_DEF = 2'b01;

    localparam logic [3:0] OP_RD1 = 4'b0001;
    localparam logic [3:0] OP_RD2 = 4'b0010;
    localparam logic [3:0] OP_WR1 = 4'b0100;
    localparam logic [3:0] OP_WR2 = 4'b1000;

    localparam logic [1:0] ENC_RD1 = 2'b00;
    localparam logic [1:0] ENC_RD2 = 2'b01;
    localparam logic [1:0] ENC_WR1 = 2'b10;
    localparam logic [1:0] ENC_WR2 = 2'b11;

    typedef struct packed {
        logic [PKG_AW-1:0] addr;
        logic [7:0]        mode;
        logic [PKG_DW-1:0] data;
    } tx_frame_t;

    // Flags 6 and 2 share one mode bit; the rest map straight through.
    function automatic logic [5:0] fail_compress(input logic [6:0] f);
        return {f[6] | f[2], f[5:3], f[1:0]};
    endfunction

    function automatic logic [1:0] op_encode(input logic [3:0] op);
        logic [1:0] enc;
        case (op)
            OP_RD1:  enc = ENC_RD1;
            OP_RD2:  enc = ENC_RD2;
            OP_WR1:  enc = ENC_WR1;
            OP_WR2:  enc = ENC_WR2;
            default: enc = ENC_RD1;
        endcase
        return enc;
    endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous FIFO of frames with asynchronous active-high reset.
//   clk, reset : clock / async reset (pointers cleared, storage left as-is)
//   push, din  : write request and frame; accepted when not full, or when a
//                pop happens in the same cycle (full FIFO read+write)
//   pop, dout  : read request and head-of-queue frame (dout is combinational)
//   full/empty : status flags; level : number of stored entries
// DEPTH must be a power of two, >= 2; pointers carry one wrap bit so that
// full and empty are distinguished without a separate counter.
module frame_fifo
    import i2c_uart_pkg::*;
#(
    parameter type T     = tx_frame_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       din,
    input  logic                   pop,
    output T                       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PW = $clog2(DEPTH);

    T                mem [DEPTH];
    logic [PW:0]     wptr;
    logic [PW:0]     rptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign level   = wptr - rptr;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (PW+1)'(1);
            if (do_pop)  rptr <= rptr + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/i2c_uart_tx_scheduler.sv
// Schedules I2C controller results as {address, mode, data} frames to the UART.
//   clk, reset           : clock, asynchronous active-high reset
//   i2c_data_rdy         : one-cycle strobe, result valid this cycle
//   i2c_valid_instr      : 11 = PC instruction (queued losslessly in the FIFO),
//                          01 = default sample (latest-value slot), else ignored
//   i2c_retrieved_data, i2c_instr_address, i2c_op_info[3:0], failure_signal
//                        : result payload, encoded into a frame on capture
//   frame_ready          : UART accepts the frame this cycle
//   clear_status         : clears overflow_sticky and drop_count (wins over events)
//   frame_valid, toPC_*  : output frame register
//   full/empty_i2cbuffer, fifo_level : PC-result FIFO status
//   overflow_sticky      : a PC result was dropped because the FIFO was full
//   drop_count           : default samples overwritten before being sent (saturating)
//
// Output handshake: a frame transfers on any cycle where frame_valid and
// frame_ready are both high. Once frame_valid rises, the frame fields stay
// constant until that transfer; a new frame may load in the same cycle as the
// transfer, so frames can go out back-to-back with no idle cycle.
module i2c_uart_tx_scheduler
    import i2c_uart_pkg::*;
#(
    parameter int DW           = 16,
    parameter int AW           = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_PC_BURST = 4,
    parameter int CNT_W        = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i2c_data_rdy,
    input  logic [1:0]             i2c_valid_instr,
    input  logic [DW-1:0]          i2c_retrieved_data,
    input  logic [AW-1:0]          i2c_instr_address,
    input  logic [7:0]             i2c_op_info,
    input  logic [6:0]             failure_signal,
    input  logic                   frame_ready,
    input  logic                   clear_status,
    output logic                   frame_valid,
    output logic [AW-1:0]          toPC_address,
    output logic [7:0]             toPC_mode,
    output logic [DW-1:0]          toPC_data,
    output logic                   full_i2cbuffer,
    output logic                   empty_i2cbuffer,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow_sticky,
    output logic [CNT_W-1:0]       drop_count
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    mode;
        logic [DW-1:0] data;
    } frame_t;

    localparam int BW = $clog2(MAX_PC_BURST + 1);

    frame_t          pc_frame;
    frame_t          def_frame;
    frame_t          fifo_dout;
    frame_t          slot_q;
    frame_t          out_q;
    logic            pending_q;
    logic [BW-1:0]   burst_q;

    logic            pc_strobe;
    logic            def_strobe;
    logic            out_free;
    logic            sel_fifo;
    logic            sel_slot;
    logic            fifo_full;
    logic            fifo_empty;
    logic            overflow_evt;
    logic            drop_evt;
    logic            unused_op_hi;

    assign unused_op_hi = ^i2c_op_info[7:4];

    assign pc_strobe  = i2c_data_rdy && (i2c_valid_instr == VALID_PC);
    assign def_strobe = i2c_data_rdy && (i2c_valid_instr == VALID_DEF);

    assign pc_frame  = '{addr: i2c_instr_address,
                         mode: {fail_compress(failure_signal), op_encode(i2c_op_info[3:0])},
                         data: i2c_retrieved_data};
    assign def_frame = '{addr: '0,
                         mode: {fail_compress(failure_signal), ENC_RD2},
                         data: i2c_retrieved_data};

    // PC frames win unless a default sample has waited through MAX_PC_BURST
    // consecutive PC frames; the burst count only advances while one is pending.
    assign out_free = !frame_valid || frame_ready;
    assign sel_fifo = out_free && !fifo_empty &&
                      (!pending_q || (burst_q < BW'(MAX_PC_BURST)));
    assign sel_slot = out_free && !sel_fifo && pending_q;

    // A full FIFO still takes a write when it is popped in the same cycle.
    assign overflow_evt = pc_strobe && fifo_full && !sel_fifo;
    assign drop_evt     = def_strobe && pending_q && !sel_slot;

    frame_fifo #(
        .T     (frame_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pc_strobe),
        .din   (pc_frame),
        .pop   (sel_fifo),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_valid <= 1'b0;
            out_q       <= '0;
        end else if (out_free) begin
            if (sel_fifo) begin
                frame_valid <= 1'b1;
                out_q       <= fifo_dout;
            end else if (sel_slot) begin
                frame_valid <= 1'b1;
                out_q       <= slot_q;
            end else begin
                frame_valid <= 1'b0;
            end
        end
    end

    // Default-sample slot and starvation counter. A new sample arriving in the
    // cycle the slot is unloaded becomes the next pending sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            slot_q    <= '0;
            burst_q   <= '0;
        end else begin
            if (def_strobe) begin
                pending_q <= 1'b1;
                slot_q    <= def_frame;
            end else if (sel_slot) begin
                pending_q <= 1'b0;
            end

            if (sel_fifo) begin
                burst_q <= pending_q ? burst_q + BW'(1) : '0;
            end else if (sel_slot) begin
                burst_q <= '0;
            end
        end
    end

    // Status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_sticky <= 1'b0;
            drop_count      <= '0;
        end else if (clear_status) begin
            overflow_sticky <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (overflow_evt) overflow_sticky <= 1'b1;
            if (drop_evt && (drop_count != {CNT_W{1'b1}})) drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign toPC_address    = out_q.addr;
    assign toPC_mode       = out_q.mode;
    assign toPC_data       = out_q.data;
    assign full_i2cbuffer  = fifo_full;
    assign empty_i2cbuffer = fifo_empty;

endmodule

// File: tb/tb_i2c_uart_tx_scheduler.sv
// Testbench for i2c_uart_tx_scheduler (default parameters).
module tb_i2c_uart_tx_scheduler;

    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i2c_data_rdy = 1'b0;
    logic [1:0]  i2c_valid_instr = 2'b00;
    logic [15:0] i2c_retrieved_data = '0;
    logic [7:0]  i2c_instr_address = '0;
    logic [7:0]  i2c_op_info = '0;
    logic [6:0]  failure_signal = '0;
    logic        frame_ready = 1'b0;
    logic        clear_status = 1'b0;
    logic        frame_valid;
    logic [7:0]  toPC_address;
    logic [7:0]  toPC_mode;
    logic [15:0] toPC_data;
    logic        full_i2cbuffer;
    logic        empty_i2cbuffer;
    logic [2:0]  fifo_level;
    logic        overflow_sticky;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    i2c_uart_tx_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .i2c_data_rdy       (i2c_data_rdy),
        .i2c_valid_instr    (i2c_valid_instr),
        .i2c_retrieved_data (i2c_retrieved_data),
        .i2c_instr_address  (i2c_instr_address),
        .i2c_op_info        (i2c_op_info),
        .failure_signal     (failure_signal),
        .frame_ready        (frame_ready),
        .clear_status       (clear_status),
        .frame_valid        (frame_valid),
        .toPC_address       (toPC_address),
        .toPC_mode          (toPC_mode),
        .toPC_data          (toPC_data),
        .full_i2cbuffer     (full_i2cbuffer),
        .empty_i2cbuffer    (empty_i2cbuffer),
        .fifo_level         (fifo_level),
        .overflow_sticky    (overflow_sticky),
        .drop_count         (drop_count)
    );

    // ---------------- reference model ----------------
    // Frames are {addr[7:0], mode[7:0], data[15:0]}.
    logic [31:0] m_fifo[$];
    bit          m_pend;
    logic [31:0] m_slot;
    int          m_burst;
    bit          m_valid;
    logic [31:0] m_out;
    bit          m_sticky;
    int          m_drops;

    // scoreboard: frames the model says were transferred vs. frames the DUT transferred
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    function automatic logic [7:0] ref_mode(input logic [6:0] f, input logic [1:0] op);
        logic [5:0] fb;
        fb = {f[6] | f[2], f[5], f[4], f[3], f[1], f[0]};
        return {fb, op};
    endfunction

    function automatic logic [1:0] ref_op(input logic [3:0] op);
        if (op == 4'b0001) return 2'd0;
        if (op == 4'b0010) return 2'd1;
        if (op == 4'b0100) return 2'd2;
        if (op == 4'b1000) return 2'd3;
        return 2'd0;
    endfunction

    function automatic void model_reset();
        m_fifo.delete();
        m_pend = 0; m_slot = '0; m_burst = 0;
        m_valid = 0; m_out = '0; m_sticky = 0; m_drops = 0;
    endfunction

    function automatic void model_step(input bit rdy, input logic [1:0] vi, input logic [7:0] addr,
                                       input logic [15:0] data, input logic [3:0] op,
                                       input logic [6:0] fail, input bit ready, input bit clr);
        bit free, was_full, take_pc, take_def, ovf, drop;
        free     = !m_valid || ready;
        was_full = (m_fifo.size() == DEPTH);
        take_pc  = free && (m_fifo.size() > 0) && (!m_pend || m_burst < MAXB);
        take_def = free && !take_pc && m_pend;
        if (m_valid && ready) exp_q.push_back(m_out);
        if (take_pc) begin
            m_out   = m_fifo.pop_front();
            m_valid = 1;
            m_burst = m_pend ? m_burst + 1 : 0;
        end else if (take_def) begin
            m_out   = m_slot;
            m_valid = 1;
            m_pend  = 0;
            m_burst = 0;
        end else if (free) begin
            m_valid = 0;
        end
        ovf = 0; drop = 0;
        if (rdy && vi == 2'b11) begin
            if (was_full && !take_pc) ovf = 1;
            else m_fifo.push_back({addr, ref_mode(fail, ref_op(op)), data});
        end
        if (rdy && vi == 2'b01) begin
            if (m_pend) drop = 1;
            m_slot = {8'h00, ref_mode(fail, 2'd1), data};
            m_pend = 1;
        end
        if (clr) begin
            m_sticky = 0; m_drops = 0;
        end else begin
            if (ovf) m_sticky = 1;
            if (drop && m_drops < 255) m_drops++;
        end
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; drives one cycle of inputs, advances the model at
    // the edge and returns at the next posedge+1.
    task automatic drive_cycle(input bit rdy, input logic [1:0] vi, input logic [7:0] addr,
                               input logic [15:0] data, input logic [3:0] op,
                               input logic [6:0] fail, input bit ready, input bit clr);
        i2c_data_rdy       = rdy;
        i2c_valid_instr    = vi;
        i2c_instr_address  = addr;
        i2c_retrieved_data = data;
        i2c_op_info        = {4'b0000, op};
        failure_signal     = fail;
        frame_ready        = ready;
        clear_status       = clr;
        #1;
        if (frame_valid && frame_ready) got_q.push_back({toPC_address, toPC_mode, toPC_data});
        @(posedge clk);
        model_step(rdy, vi, addr, data, op, fail, ready, clr);
        #1;
    endtask

    task automatic idle(input bit ready, input int n);
        for (int i = 0; i < n; i++) drive_cycle(0, 2'b00, 8'h00, 16'h0000, 4'b0000, 7'h00, ready, 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", frame_valid); end
        total++; if ({toPC_address, toPC_mode, toPC_data} !== 32'h0) begin bad++; $display("FAIL reset_frame got=%h exp=0", {toPC_address, toPC_mode, toPC_data}); end
        total++; if (empty_i2cbuffer !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty_i2cbuffer); end
        total++; if (full_i2cbuffer !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full_i2cbuffer); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        total++; if (overflow_sticky !== 1'b0 || drop_count !== 8'd0) begin bad++; $display("FAIL reset_status got=%0b/%0d exp=0/0", overflow_sticky, drop_count); end
        reset = 1'b0;
    endtask

    task automatic test_single_pc();
        exp_q.delete(); got_q.delete();
        drive_cycle(1, 2'b11, 8'h48, 16'h1A2B, 4'b0010, 7'h00, 0, 0);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%0b exp=0", frame_valid); end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        idle(0, 1);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL single_lat2 got=%0b exp=1", frame_valid); end
        total++; if ({toPC_address, toPC_mode, toPC_data} !== 32'h4801_1A2B) begin bad++; $display("FAIL single_frame got=%h exp=48011a2b", {toPC_address, toPC_mode, toPC_data}); end
        idle(0, 2);
        total++; if (frame_valid !== 1'b1 || toPC_data !== 16'h1A2B) begin bad++; $display("FAIL single_hold got=%0b/%h exp=1/1a2b", frame_valid, toPC_data); end
        idle(1, 1);
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b exp=0", frame_valid); end
        total++; if (got_q.size() != 1 || got_q[0] !== 32'h4801_1A2B) begin bad++; $display("FAIL single_sent got=%0d frames exp=1", got_q.size()); end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 6; i++)
            drive_cycle(1, 2'b11, 8'(8'h10 + i), 16'(16'hA000 + i), 4'b0001, 7'h00, 0, 0);
        total++; if (full_i2cbuffer !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b exp=1", full_i2cbuffer); end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
        total++; if (overflow_sticky !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_sticky); end
        idle(1, 8);
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL ovf_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            e = {8'(8'h10 + i), 8'h00, 16'(16'hA000 + i)};
            total++; if (got_q[i] !== e) begin bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, got_q[i], e); end
        end
        drive_cycle(0, 2'b00, 8'h00, 16'h0000, 4'b0000, 7'h00, 1, 1);
        total++; if (overflow_sticky !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b exp=0", overflow_sticky); end
        total++; if (empty_i2cbuffer !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%0b exp=1", empty_i2cbuffer); end
    endtask

    task automatic test_default_drop();
        exp_q.delete(); got_q.delete();
        drive_cycle(1, 2'b11, 8'h22, 16'h5555, 4'b0001, 7'h00, 0, 0);
        idle(0, 1);
        drive_cycle(1, 2'b01, 8'h00, 16'h0100, 4'b0000, 7'h00, 0, 0);
        drive_cycle(1, 2'b01, 8'h00, 16'h0200, 4'b0000, 7'h00, 0, 0);
        drive_cycle(1, 2'b01, 8'h00, 16'h0300, 4'b0000, 7'h00, 0, 0);
        total++; if (drop_count !== 8'd2) begin bad++; $display("FAIL drop_count got=%0d exp=2", drop_count); end
        idle(1, 4);
        total++; if (got_q.size() != 2) begin bad++; $display("FAIL drop_sent got=%0d exp=2", got_q.size()); end
        if (got_q.size() == 2) begin
            total++; if (got_q[0] !== 32'h2200_5555) begin bad++; $display("FAIL drop_pc got=%h exp=22005555", got_q[0]); end
            total++; if (got_q[1] !== 32'h0001_0300) begin bad++; $display("FAIL drop_latest got=%h exp=00010300", got_q[1]); end
        end
        drive_cycle(0, 2'b00, 8'h00, 16'h0000, 4'b0000, 7'h00, 1, 1);
        total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL drop_clear got=%0d exp=0", drop_count); end
    endtask

    task automatic test_fail_map();
        drive_cycle(1, 2'b11, 8'h33, 16'hBEEF, 4'b0100, 7'b1000001, 0, 0);
        idle(0, 1);
        total++; if (toPC_mode !== 8'b10000110 || toPC_address !== 8'h33 || toPC_data !== 16'hBEEF) begin bad++; $display("FAIL fail_wr1 got=%h/%h/%h exp=86/33/beef", toPC_mode, toPC_address, toPC_data); end
        idle(1, 1);
        drive_cycle(1, 2'b11, 8'h34, 16'h1234, 4'b0110, 7'b0000100, 0, 0);
        idle(0, 1);
        total++; if (toPC_mode !== 8'h80) begin bad++; $display("FAIL fail_nonhot got=%h exp=80", toPC_mode); end
        idle(1, 1);
        drive_cycle(1, 2'b01, 8'h77, 16'h4242, 4'b1000, 7'b0100000, 0, 0);
        idle(0, 1);
        total++; if (toPC_mode !== 8'h41 || toPC_address !== 8'h00 || toPC_data !== 16'h4242) begin bad++; $display("FAIL fail_default got=%h/%h/%h exp=41/00/4242", toPC_mode, toPC_address, toPC_data); end
        drive_cycle(1, 2'b10, 8'h01, 16'h0001, 4'b0001, 7'h00, 1, 0);
        idle(1, 2);
        total++; if (frame_valid !== 1'b0 || fifo_level !== 3'd0) begin bad++; $display("FAIL fail_ignore got=%0b/%0d exp=0/0", frame_valid, fifo_level); end
    endtask

    task automatic test_burst();
        logic [31:0] e;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 5; i++)
            drive_cycle(1, 2'b11, 8'(8'h40 + i), 16'(16'hC000 + i), 4'b0010, 7'h00, 0, 0);
        drive_cycle(1, 2'b01, 8'h00, 16'hD00D, 4'b0000, 7'h00, 0, 0);
        for (int i = 5; i < 9; i++)
            drive_cycle(1, 2'b11, 8'(8'h40 + i), 16'(16'hC000 + i), 4'b0010, 7'h00, 1, 0);
        total++; if (overflow_sticky !== 1'b0) begin bad++; $display("FAIL burst_push_pop got=%0b exp=0", overflow_sticky); end
        idle(1, 12);
        total++; if (got_q.size() != 10) begin bad++; $display("FAIL burst_count got=%0d exp=10", got_q.size()); end
        for (int k = 0; k < 10 && k < got_q.size(); k++) begin
            if (k < 5)       e = {8'(8'h40 + k), 8'h01, 16'(16'hC000 + k)};
            else if (k == 5) e = 32'h0001_D00D;
            else             e = {8'(8'h40 + k - 1), 8'h01, 16'(16'hC000 + k - 1)};
            total++; if (got_q[k] !== e) begin bad++; $display("FAIL burst_order[%0d] got=%h exp=%h", k, got_q[k], e); end
        end
    endtask

    task automatic test_random();
        logic [3:0]  ops [5];
        logic [1:0]  vis [4];
        logic [31:0] dut_frame;
        ops = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101};
        vis = '{2'b11, 2'b01, 2'b00, 2'b10};
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 400; c++) begin
            drive_cycle(1'($urandom_range(0, 1)), vis[$urandom_range(0, 3)], 8'($urandom),
                        16'($urandom), ops[$urandom_range(0, 4)], 7'($urandom),
                        $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
            dut_frame = {toPC_address, toPC_mode, toPC_data};
            total++; if (frame_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, frame_valid, m_valid); end
            if (m_valid) begin
                total++; if (dut_frame !== m_out) begin bad++; $display("FAIL rnd_frame c=%0d got=%h exp=%h", c, dut_frame, m_out); end
            end
            total++; if (fifo_level !== 3'(m_fifo.size())) begin bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, m_fifo.size()); end
            total++; if (full_i2cbuffer !== (m_fifo.size() == DEPTH) || empty_i2cbuffer !== (m_fifo.size() == 0)) begin bad++; $display("FAIL rnd_flags c=%0d got=%0b%0b exp_size=%0d", c, full_i2cbuffer, empty_i2cbuffer, m_fifo.size()); end
            total++; if (overflow_sticky !== m_sticky) begin bad++; $display("FAIL rnd_sticky c=%0d got=%0b exp=%0b", c, overflow_sticky, m_sticky); end
            total++; if (drop_count !== 8'(m_drops)) begin bad++; $display("FAIL rnd_drops c=%0d got=%0d exp=%0d", c, drop_count, m_drops); end
        end
        idle(1, 20);
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_sent_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd_sent[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 4; i++)
            drive_cycle(1, 2'b11, 8'(8'h60 + i), 16'(16'hE000 + i), 4'b1000, 7'h00, 0, 0);
        total++; if (frame_valid !== 1'b1 || fifo_level !== 3'd3) begin bad++; $display("FAIL midrst_pre got=%0b/%0d exp=1/3", frame_valid, fifo_level); end
        i2c_data_rdy = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b exp=0", frame_valid); end
        total++; if ({toPC_address, toPC_mode, toPC_data} !== 32'h0) begin bad++; $display("FAIL midrst_frame got=%h exp=0", {toPC_address, toPC_mode, toPC_data}); end
        total++; if (empty_i2cbuffer !== 1'b1 || fifo_level !== 3'd0) begin bad++; $display("FAIL midrst_fifo got=%0b/%0d exp=1/0", empty_i2cbuffer, fifo_level); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1, 4);
        total++; if (frame_valid !== 1'b0 || got_q.size() != 0) begin bad++; $display("FAIL midrst_stale got=%0b/%0d exp=0/0", frame_valid, got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_pc();
        test_overflow();
        test_default_drop();
        test_fail_map();
        test_burst();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
